decimal_req_scheduler: RTL and testbench



---
 rtl/decimal_req_scheduler_pkg.sv | 27 ++
 rtl/decimal_req_scheduler_if.sv | 14 +
 rtl/decimal_req_scheduler_enc.sv | 25 ++
 rtl/decimal_req_scheduler.sv | 66 ++++++
 tb/tb_decimal_req_scheduler.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/decimal_req_scheduler_pkg.sv
// decimal_req_scheduler_pkg: shared constants, FSM state type and the digit picker
package decimal_pkg;
    localparam int NUM_DIGITS = 10;
    localparam int BCD_W = 4;

    typedef enum logic {IDLE, PRESENT} state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Scanning offsets high-to-low and overwriting leaves the first hit from start
    function automatic pick_t rr_pick(input logic [NUM_DIGITS-1:0] pend, input logic [3:0] last_ptr, input logic rr_en);
        pick_t p;
        int    start;
        int    j;
        p = '0;
        start = rr_en ? int'(last_ptr) + 1 : 0;
        for (int o = NUM_DIGITS - 1; o >= 0; o--) begin
            j = start + o;
            if (j >= NUM_DIGITS) j = j - NUM_DIGITS;
            if (pend[j]) p = '{found: 1'b1, idx: 4'(j)};
        end
        return p;
    endfunction
endpackage

// File: rtl/decimal_req_scheduler_if.sv
// decimal_req_scheduler_if: digit requests in, BCD valid/ready stream and status out
interface decimal_req_scheduler_if;
    import decimal_pkg::*;
    logic [NUM_DIGITS-1:0] req;
    logic                  out_ready;
    logic [BCD_W-1:0]      bcd;
    logic                  bcd_valid;
    logic [NUM_DIGITS-1:0] grant;
    logic [NUM_DIGITS-1:0] pending;
    logic                  overrun;

    modport slave (input req, out_ready, output bcd, bcd_valid, grant, pending, overrun);
    modport master (output req, out_ready, input bcd, bcd_valid, grant, pending, overrun);
endinterface

// File: rtl/decimal_req_scheduler_enc.sv
// decimaltoBCD_Encoder: combinational one-hot decimal digit to BCD encoder
module decimaltoBCD_Encoder (
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic D4,
    input  logic D5,
    input  logic D6,
    input  logic D7,
    input  logic D8,
    input  logic D9,
    output logic B0,
    output logic B1,
    output logic B2,
    output logic B3
);
    // Digit 0 encodes to all zeros, so D0 contributes to no output bit
    logic w_unused_d0;
    assign w_unused_d0 = D0;
    assign B0 = D1 | D3 | D5 | D7 | D9;
    assign B1 = D2 | D3 | D6 | D7;
    assign B2 = D4 | D5 | D6 | D7;
    assign B3 = D8 | D9;
endmodule

// File: rtl/decimal_req_scheduler.sv
// decimal_req_scheduler: captures digit request edges and serialises them as BCD codes
module decimal_req_scheduler
    import decimal_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input logic clk,
    input logic rst_n,
    decimal_req_scheduler_if.slave bus
);
    state_t                r_state, w_state_nxt;
    logic [NUM_DIGITS-1:0] r_req_q, r_pending, r_grant;
    logic [NUM_DIGITS-1:0] w_rise, w_clr, w_grant_nxt;
    logic [BCD_W-1:0]      r_bcd, w_enc;
    logic [3:0]            r_last_ptr;
    logic                  r_overrun, w_go, w_load, w_drop;
    pick_t                 w_pick;

    assign w_rise = bus.req & ~r_req_q;
    assign w_pick = rr_pick(r_pending, r_last_ptr, RR_EN);
    assign w_clr = w_load ? {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_pick.idx : '0;
    assign w_grant_nxt = w_load ? w_clr : (w_drop ? '0 : r_grant);

    always_comb begin
        w_go = (r_state == IDLE) | bus.out_ready;
        w_load = w_go & w_pick.found;
        w_drop = w_go & ~w_pick.found & (r_state == PRESENT);
        w_state_nxt = w_load ? PRESENT : (w_drop ? IDLE : r_state);
    end

    decimaltoBCD_Encoder u_enc (
        .D0(w_grant_nxt[0]), .D1(w_grant_nxt[1]), .D2(w_grant_nxt[2]), .D3(w_grant_nxt[3]),
        .D4(w_grant_nxt[4]), .D5(w_grant_nxt[5]), .D6(w_grant_nxt[6]), .D7(w_grant_nxt[7]),
        .D8(w_grant_nxt[8]), .D9(w_grant_nxt[9]),
        .B0(w_enc[0]), .B1(w_enc[1]), .B2(w_enc[2]), .B3(w_enc[3])
    );

    // req_q resets to all-ones so keys held through reset raise no event
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req_q <= '1;
            r_pending <= '0;
            r_grant <= '0;
            r_bcd <= '0;
            r_overrun <= 1'b0;
            r_last_ptr <= 4'd9;
        end else begin
            r_state <= w_state_nxt;
            r_req_q <= bus.req;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_overrun <= |(w_rise & r_pending & ~w_clr);
            r_grant <= w_grant_nxt;
            if (w_load) begin
                r_bcd <= w_enc;
                r_last_ptr <= w_pick.idx;
            end
        end
    end

    assign bus.bcd = r_bcd;
    assign bus.bcd_valid = (r_state == PRESENT);
    assign bus.grant = r_grant;
    assign bus.pending = r_pending;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_decimal_req_scheduler.sv
// tb_decimal_req_scheduler: directed checks on round-robin and fixed-priority instances
module tb_decimal_req_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    decimal_req_scheduler_if a ();
    decimal_req_scheduler_if b ();

    decimal_req_scheduler #(.RR_EN(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    decimal_req_scheduler #(.RR_EN(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] e_bcd, input logic e_v, input logic [9:0] e_g, input logic [9:0] e_p);
        chk({tag, " bcd"}, 32'(a.bcd), 32'(e_bcd));
        chk({tag, " valid"}, 32'(a.bcd_valid), 32'(e_v));
        chk({tag, " grant"}, 32'(a.grant), 32'(e_g));
        chk({tag, " pending"}, 32'(a.pending), 32'(e_p));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        a.req = '0; a.out_ready = 1'b1;
        b.req = '0; b.out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        chk_a("reset", 4'd0, 1'b0, 10'h000, 10'h000);
        chk("reset overrun", 32'(a.overrun), 32'd0);
        rst_n = 1'b1;
        tick();
        // single digit 7
        a.req = 10'h080;
        tick();
        chk_a("t1 capture", 4'd0, 1'b0, 10'h000, 10'h080);
        a.req = '0;
        tick();
        chk_a("t1 present", 4'd7, 1'b1, 10'h080, 10'h000);
        tick();
        chk_a("t1 idle", 4'd7, 1'b0, 10'h000, 10'h000);
        // round robin 2,5,9 then wrap to 0
        do_reset();
        a.req = 10'h224;
        tick();
        chk_a("t2 capture", 4'd0, 1'b0, 10'h000, 10'h224);
        a.req = '0;
        tick();
        chk_a("t2 code2", 4'd2, 1'b1, 10'h004, 10'h220);
        a.req = 10'h001;
        tick();
        chk_a("t2 code5", 4'd5, 1'b1, 10'h020, 10'h201);
        tick();
        chk_a("t2 code9", 4'd9, 1'b1, 10'h200, 10'h001);
        tick();
        chk_a("t2 code0", 4'd0, 1'b1, 10'h001, 10'h000);
        a.req = '0;
        tick();
        chk_a("t2 idle", 4'd0, 1'b0, 10'h000, 10'h000);
        // fixed priority 3 before 8
        b.req = 10'h108;
        tick();
        chk("t3 pending", 32'(b.pending), 32'h108);
        b.req = '0;
        tick();
        chk("t3 first", 32'(b.bcd), 32'd3);
        chk("t3 first grant", 32'(b.grant), 32'h008);
        tick();
        chk("t3 second", 32'(b.bcd), 32'd8);
        chk("t3 second valid", 32'(b.bcd_valid), 32'd1);
        tick();
        chk("t3 idle", 32'(b.bcd_valid), 32'd0);
        // stall on code 6 while digit 1 arrives
        a.req = 10'h040;
        tick();
        a.req = '0;
        a.out_ready = 1'b0;
        tick();
        chk_a("t4 code6", 4'd6, 1'b1, 10'h040, 10'h000);
        a.req = 10'h002;
        tick();
        chk("t4 no overrun", 32'(a.overrun), 32'd0);
        a.req = '0;
        for (int i = 0; i < 4; i++) tick();
        chk_a("t4 stalled", 4'd6, 1'b1, 10'h040, 10'h002);
        a.out_ready = 1'b1;
        tick();
        chk_a("t4 code1", 4'd1, 1'b1, 10'h002, 10'h000);
        tick();
        chk("t4 idle", 32'(a.bcd_valid), 32'd0);
        // overrun on digit 4 while code 3 is stalled
        a.req = 10'h018;
        a.out_ready = 1'b0;
        tick();
        a.req = '0;
        tick();
        chk_a("t5 code3", 4'd3, 1'b1, 10'h008, 10'h010);
        a.req = 10'h010;
        tick();
        chk("t5 overrun", 32'(a.overrun), 32'd1);
        chk("t5 pending", 32'(a.pending), 32'h010);
        a.req = '0;
        tick();
        chk("t5 overrun clear", 32'(a.overrun), 32'd0);
        a.out_ready = 1'b1;
        tick();
        chk_a("t5 code4", 4'd4, 1'b1, 10'h010, 10'h000);
        tick();
        chk_a("t5 idle", 4'd4, 1'b0, 10'h000, 10'h000);
        // reset mid-transfer with digit 5 held
        a.req = 10'h001;
        a.out_ready = 1'b0;
        tick();
        a.req = '0;
        tick();
        chk_a("t6 code0", 4'd0, 1'b1, 10'h001, 10'h000);
        a.req = 10'h0A0;
        tick();
        chk("t6 pending", 32'(a.pending), 32'h0A0);
        rst_n = 1'b0;
        tick();
        chk_a("t6 reset", 4'd0, 1'b0, 10'h000, 10'h000);
        rst_n = 1'b1;
        a.out_ready = 1'b1;
        tick();
        tick();
        chk_a("t6 held", 4'd0, 1'b0, 10'h000, 10'h000);
        a.req = 10'h080;
        tick();
        a.req = 10'h0A0;
        tick();
        chk("t6 re-press", 32'(a.pending), 32'h020);
        tick();
        chk_a("t6 code5", 4'd5, 1'b1, 10'h020, 10'h000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
